// File: rtl/mips_cpu_regfile_wb_arbiter_if.sv
// Writeback arbiter bundle: ALU/load requesters, decode issue/hazard
// signals and the registered register-file write port.
interface mips_cpu_regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    logic              issue_valid;
    logic              issue_ready;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              stall;

    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        output issue_valid, issue_addr, rs_addr, rt_addr,
        input  alu_ready, ld_ready, issue_ready, stall,
        input  w_en, w_addr, w_data
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        input  issue_valid, issue_addr, rs_addr, rt_addr,
        output alu_ready, ld_ready, issue_ready, stall,
        output w_en, w_addr, w_data
    );
endinterface

// File: rtl/mips_cpu_regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writebacks
// and tracks per-register pending writes for RAW/WAW hazard detection.
module mips_cpu_regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic reset,
    mips_cpu_regfile_wb_arbiter_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic                rr_ld_q, rr_ld_d;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                w_en_q, w_en_d;
    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;

    logic                both;
    logic                gnt_ld;
    logic                gnt_alu;
    logic                gnt_any;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_data;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] set_vec;
    logic                iss_ok;
    logic                rs_hz;
    logic                rt_hz;

    // rr_ld_q set means load wins the next contended cycle
    always_comb begin
        both     = bus.alu_valid && bus.ld_valid;
        gnt_ld   = bus.ld_valid &&
                   (!bus.alu_valid || (FIXED_PRIO != 0) || rr_ld_q);
        gnt_alu  = bus.alu_valid && !gnt_ld;
        gnt_any  = gnt_ld || gnt_alu;
        gnt_addr = gnt_ld ? bus.ld_addr : bus.alu_addr;
        gnt_data = gnt_ld ? bus.ld_data : bus.alu_data;
        rr_ld_d  = rr_ld_q;
        if (both) begin
            rr_ld_d = !gnt_ld;
        end
    end

    always_comb begin
        clr_vec = '0;
        if (gnt_any) begin
            clr_vec[gnt_addr] = 1'b1;
        end
        iss_ok = (bus.issue_addr == '0) ||
                 !pend_q[bus.issue_addr] ||
                 clr_vec[bus.issue_addr];
        set_vec = '0;
        if (bus.issue_valid && iss_ok && (bus.issue_addr != '0)) begin
            set_vec[bus.issue_addr] = 1'b1;
        end
        // set is applied after clear so a same-cycle reissue stays pending
        pend_d    = (pend_q & ~clr_vec) | set_vec;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        rs_hz = (bus.rs_addr != '0) && pend_q[bus.rs_addr];
        rt_hz = (bus.rt_addr != '0) && pend_q[bus.rt_addr];
    end

    always_comb begin
        w_en_d   = gnt_any && (gnt_addr != '0);
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (w_en_d) begin
            w_addr_d = gnt_addr;
            w_data_d = gnt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ld_q  <= 1'b1;
            pend_q   <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            rr_ld_q  <= rr_ld_d;
            pend_q   <= pend_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    assign bus.alu_ready   = gnt_alu;
    assign bus.ld_ready    = gnt_ld;
    assign bus.issue_ready = iss_ok;
    assign bus.stall       = rs_hz || rt_hz;
    assign bus.w_en        = w_en_q;
    assign bus.w_addr      = w_addr_q;
    assign bus.w_data      = w_data_q;

endmodule

// File: tb/tb_mips_cpu_regfile_wb_arbiter.sv
// Bench for the writeback arbiter: round-robin (dut 0) and fixed-priority
// (dut 1) instances driven in lockstep and checked against a reference model.
module tb_mips_cpu_regfile_wb_arbiter;
    logic clk;
    logic rst;
    logic alu_valid, ld_valid, issue_valid;
    logic [4:0] alu_addr, ld_addr, issue_addr, rs_addr, rt_addr;
    logic [31:0] alu_data, ld_data;

    int checks = 0;
    int errors = 0;

    mips_cpu_regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
    mips_cpu_regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) ifb ();

    mips_cpu_regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(0))
        dut_rr (.clk(clk), .reset(rst), .bus(ifa));
    mips_cpu_regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1))
        dut_fx (.clk(clk), .reset(rst), .bus(ifb));

    assign ifa.alu_valid = alu_valid;   assign ifb.alu_valid = alu_valid;
    assign ifa.alu_addr = alu_addr;     assign ifb.alu_addr = alu_addr;
    assign ifa.alu_data = alu_data;     assign ifb.alu_data = alu_data;
    assign ifa.ld_valid = ld_valid;     assign ifb.ld_valid = ld_valid;
    assign ifa.ld_addr = ld_addr;       assign ifb.ld_addr = ld_addr;
    assign ifa.ld_data = ld_data;       assign ifb.ld_data = ld_data;
    assign ifa.issue_valid = issue_valid; assign ifb.issue_valid = issue_valid;
    assign ifa.issue_addr = issue_addr; assign ifb.issue_addr = issue_addr;
    assign ifa.rs_addr = rs_addr;       assign ifb.rs_addr = rs_addr;
    assign ifa.rt_addr = rt_addr;       assign ifb.rt_addr = rt_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, index 0 = round-robin, 1 = load-priority
    bit          m_pend [2][32];
    bit          m_last_alu [2];
    bit          m_wen [2];
    logic [4:0]  m_waddr [2];
    logic [31:0] m_wdata [2];

    bit e_alu_rdy [2], e_ld_rdy [2], e_iss_rdy [2], e_stall [2];
    logic o_alu_rdy [2], o_ld_rdy [2], o_iss_rdy [2], o_stall [2];
    logic o_wen [2];
    logic [4:0] o_waddr [2];
    logic [31:0] o_wdata [2];

    // 0 = nobody, 1 = alu, 2 = load
    function automatic int winner(int v);
        if (alu_valid && ld_valid) begin
            if (v == 1) return 2;
            return m_last_alu[v] ? 2 : 1;
        end
        if (alu_valid) return 1;
        if (ld_valid) return 2;
        return 0;
    endfunction

    task automatic tick();
        int w [2];
        logic [4:0] a [2];
        #1;
        for (int v = 0; v < 2; v++) begin
            w[v] = winner(v);
            a[v] = (w[v] == 2) ? ld_addr : alu_addr;
            e_alu_rdy[v] = (w[v] == 1);
            e_ld_rdy[v]  = (w[v] == 2);
            e_iss_rdy[v] = (issue_addr == 0) || !m_pend[v][issue_addr] ||
                           (w[v] != 0 && a[v] == issue_addr);
            e_stall[v] = (rs_addr != 0 && m_pend[v][rs_addr]) ||
                         (rt_addr != 0 && m_pend[v][rt_addr]);
        end
        o_alu_rdy[0] = ifa.alu_ready;  o_alu_rdy[1] = ifb.alu_ready;
        o_ld_rdy[0]  = ifa.ld_ready;   o_ld_rdy[1]  = ifb.ld_ready;
        o_iss_rdy[0] = ifa.issue_ready; o_iss_rdy[1] = ifb.issue_ready;
        o_stall[0]   = ifa.stall;      o_stall[1]   = ifb.stall;
        @(posedge clk);
        for (int v = 0; v < 2; v++) begin
            if (rst) begin
                for (int r = 0; r < 32; r++) m_pend[v][r] = 0;
                m_last_alu[v] = 1;
                m_wen[v] = 0;
                m_waddr[v] = 0;
                m_wdata[v] = 0;
            end else begin
                m_wen[v] = 0;
                if (w[v] != 0) begin
                    if (alu_valid && ld_valid) m_last_alu[v] = (w[v] == 1);
                    m_pend[v][a[v]] = 0;
                    if (a[v] != 0) begin
                        m_wen[v] = 1;
                        m_waddr[v] = a[v];
                        m_wdata[v] = (w[v] == 2) ? ld_data : alu_data;
                    end
                end
                if (issue_valid && e_iss_rdy[v] && issue_addr != 0)
                    m_pend[v][issue_addr] = 1;
            end
        end
        @(negedge clk);
        o_wen[0] = ifa.w_en;     o_wen[1] = ifb.w_en;
        o_waddr[0] = ifa.w_addr; o_waddr[1] = ifb.w_addr;
        o_wdata[0] = ifa.w_data; o_wdata[1] = ifb.w_data;
    endtask

    task automatic idle();
        rst = 0; alu_valid = 0; ld_valid = 0; issue_valid = 0;
        alu_addr = 0; ld_addr = 0; issue_addr = 0;
        rs_addr = 0; rt_addr = 0; alu_data = 0; ld_data = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        rs_addr = 9; rt_addr = 31;
        tick();
        for (int v = 0; v < 2; v++) begin
            checks++;
            if (o_wen[v] !== 1'b0 || o_waddr[v] !== 5'd0 ||
                o_wdata[v] !== 32'd0) begin
                errors++;
                $display("FAIL reset_w[%0d]: got en=%b a=%0d d=%h want 0/0/0",
                         v, o_wen[v], o_waddr[v], o_wdata[v]);
            end
            checks++;
            if (o_stall[v] !== 1'b0) begin
                errors++;
                $display("FAIL reset_stall[%0d]: got %b want 0", v, o_stall[v]);
            end
        end
    endtask

    task automatic test_single_alu();
        do_reset();
        alu_valid = 1; alu_addr = 2; alu_data = 32'h0000_00AB;
        tick();
        alu_valid = 0;
        for (int v = 0; v < 2; v++) begin
            checks++;
            if (o_alu_rdy[v] !== 1'b1) begin
                errors++;
                $display("FAIL alu_ready[%0d]: got %b want 1", v, o_alu_rdy[v]);
            end
            checks++;
            if (o_wen[v] !== 1'b1 || o_waddr[v] !== 5'd2 ||
                o_wdata[v] !== 32'hAB) begin
                errors++;
                $display("FAIL alu_write[%0d]: got en=%b a=%0d d=%h want 1/2/ab",
                         v, o_wen[v], o_waddr[v], o_wdata[v]);
            end
        end
        tick();
        for (int v = 0; v < 2; v++) begin
            checks++;
            if (o_wen[v] !== 1'b0) begin
                errors++;
                $display("FAIL alu_wen_drop[%0d]: got %b want 0", v, o_wen[v]);
            end
        end
    endtask

    task automatic test_contended();
        logic [4:0] want_rr [4];
        want_rr = '{5'd4, 5'd3, 5'd4, 5'd3};
        do_reset();
        alu_valid = 1; alu_addr = 3; alu_data = 32'h3333;
        ld_valid = 1; ld_addr = 4; ld_data = 32'h4444;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (o_wen[0] !== 1'b1 || o_waddr[0] !== want_rr[i]) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got en=%b a=%0d want 1/%0d",
                         i, o_wen[0], o_waddr[0], want_rr[i]);
            end
            checks++;
            if (o_wen[1] !== 1'b1 || o_waddr[1] !== 5'd4 ||
                o_alu_rdy[1] !== 1'b0) begin
                errors++;
                $display("FAIL fx_seq[%0d]: got en=%b a=%0d rdy=%b want 1/4/0",
                         i, o_wen[1], o_waddr[1], o_alu_rdy[1]);
            end
        end
    endtask

    task automatic test_raw();
        do_reset();
        issue_valid = 1; issue_addr = 5;
        tick();
        issue_valid = 0; rs_addr = 5; rt_addr = 0;
        tick();
        alu_valid = 1; alu_addr = 5; alu_data = 32'h55;
        tick();
        for (int v = 0; v < 2; v++) begin
            checks++;
            if (o_stall[v] !== 1'b1) begin
                errors++;
                $display("FAIL raw_grant_stall[%0d]: got %b want 1", v, o_stall[v]);
            end
        end
        alu_valid = 0;
        tick();
        for (int v = 0; v < 2; v++) begin
            checks++;
            if (o_stall[v] !== 1'b0) begin
                errors++;
                $display("FAIL raw_clear[%0d]: got %b want 0", v, o_stall[v]);
            end
        end
    endtask

    task automatic test_waw();
        do_reset();
        issue_valid = 1; issue_addr = 7;
        tick();
        tick();
        for (int v = 0; v < 2; v++) begin
            checks++;
            if (o_iss_rdy[v] !== 1'b0) begin
                errors++;
                $display("FAIL waw_block[%0d]: got %b want 0", v, o_iss_rdy[v]);
            end
        end
        alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
        tick();
        alu_valid = 0; issue_valid = 0; rs_addr = 7;
        for (int v = 0; v < 2; v++) begin
            checks++;
            if (o_iss_rdy[v] !== 1'b1) begin
                errors++;
                $display("FAIL waw_release[%0d]: got %b want 1", v, o_iss_rdy[v]);
            end
        end
        tick();
        for (int v = 0; v < 2; v++) begin
            checks++;
            if (o_stall[v] !== 1'b1) begin
                errors++;
                $display("FAIL waw_still_pend[%0d]: got %b want 1", v, o_stall[v]);
            end
        end
    endtask

    task automatic test_reg0();
        do_reset();
        ld_valid = 1; ld_addr = 0; ld_data = 32'hFFFF_FFFF;
        tick();
        ld_valid = 0;
        issue_valid = 1; issue_addr = 0;
        for (int v = 0; v < 2; v++) begin
            checks++;
            if (o_ld_rdy[v] !== 1'b1 || o_wen[v] !== 1'b0) begin
                errors++;
                $display("FAIL reg0_ld[%0d]: got rdy=%b en=%b want 1/0",
                         v, o_ld_rdy[v], o_wen[v]);
            end
        end
        tick();
        issue_valid = 0;
        tick();
        for (int v = 0; v < 2; v++) begin
            checks++;
            if (o_iss_rdy[v] !== 1'b1 || o_stall[v] !== 1'b0) begin
                errors++;
                $display("FAIL reg0_issue[%0d]: got rdy=%b stall=%b want 1/0",
                         v, o_iss_rdy[v], o_stall[v]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_valid = 1; issue_addr = 9;
        tick();
        issue_valid = 0;
        alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
        rst = 1;
        tick();
        rst = 0; alu_valid = 0; rs_addr = 9;
        for (int v = 0; v < 2; v++) begin
            checks++;
            if (o_wen[v] !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_wen[%0d]: got %b want 0", v, o_wen[v]);
            end
        end
        tick();
        for (int v = 0; v < 2; v++) begin
            checks++;
            if (o_stall[v] !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_stall[%0d]: got %b want 0", v, o_stall[v]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 60) == 0);
            alu_valid = $urandom_range(0, 1);
            ld_valid = $urandom_range(0, 1);
            issue_valid = ($urandom_range(0, 2) != 0);
            alu_addr = 5'($urandom_range(0, 7));
            ld_addr = 5'($urandom_range(0, 7));
            issue_addr = 5'($urandom_range(0, 7));
            rs_addr = 5'($urandom_range(0, 7));
            rt_addr = 5'($urandom_range(0, 7));
            alu_data = $urandom;
            ld_data = $urandom;
            tick();
            for (int v = 0; v < 2; v++) begin
                checks++;
                if (o_alu_rdy[v] !== e_alu_rdy[v] || o_ld_rdy[v] !== e_ld_rdy[v]) begin
                    errors++;
                    $display("FAIL rnd_ready[%0d] cyc %0d: got alu=%b ld=%b want %b/%b",
                             v, i, o_alu_rdy[v], o_ld_rdy[v], e_alu_rdy[v], e_ld_rdy[v]);
                end
                checks++;
                if (o_iss_rdy[v] !== e_iss_rdy[v] || o_stall[v] !== e_stall[v]) begin
                    errors++;
                    $display("FAIL rnd_hazard[%0d] cyc %0d: got iss=%b st=%b want %b/%b",
                             v, i, o_iss_rdy[v], o_stall[v], e_iss_rdy[v], e_stall[v]);
                end
                checks++;
                if (o_wen[v] !== m_wen[v] ||
                    (m_wen[v] && (o_waddr[v] !== m_waddr[v] ||
                                  o_wdata[v] !== m_wdata[v]))) begin
                    errors++;
                    $display("FAIL rnd_write[%0d] cyc %0d: got %b/%0d/%h want %b/%0d/%h",
                             v, i, o_wen[v], o_waddr[v], o_wdata[v],
                             m_wen[v], m_waddr[v], m_wdata[v]);
                end
            end
        end
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_single_alu();
        test_contended();
        test_raw();
        test_waw();
        test_reg0();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
